barrel_shift_pipe: RTL and testbench
====================================

// Module: barrel_shift_pipe
// PURPOSE
//  Pipelined 8-bit barrel shifter; wraps the mux-level shift network in registered stages.
//  Stage k conditionally shifts by 2^k, so the operation completes in log2(WIDTH) stages.
//  Input and output use valid/ready handshakes, with full backpressure and 1 op/cycle throughput.
//  Sits between the operand source (switches/ALU register) and the result/display register.
// PARAMETERS
//  WIDTH  8  data width; must be a power of two >= 2
//  SHW    3  shift-amount width = log2(WIDTH); also the number of pipeline stages
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand presented
//  in_ready   out  1      stage 0 can accept this cycle
//  in_data    in   WIDTH  operand
//  in_shamt   in   SHW    shift amount, 0..WIDTH-1
//  in_mode    in   2      00 LSL, 01 LSR, 10 ASR, 11 ROR
//  out_valid  out  1      result presented
//  out_ready  in   1      consumer accepts result
//  out_data   out  WIDTH  shifted result
//  out_carry  out  1      last bit shifted out (SHIFT_STATUS_EN only)
//  out_zero   out  1      out_data == 0 (SHIFT_STATUS_EN only)
// BEHAVIOUR
//  - Reset (async, rst_n=0): all stage valid bits, data, shamt, mode and flag registers clear to 0.
//    Outputs at reset: out_valid=0, out_data=0, out_carry=0, out_zero=0; in_ready=1 once rst_n=1.
//  - Transfer rule: a transfer occurs when valid && ready in the same cycle. Otherwise no transfer.
//  - Stage k (k=0..SHW-1) holds data, remaining shamt, mode, sign bit and valid.
//    Stage 0 captures the input; stage SHW-1 drives the out_* ports directly.
//  - Stage k applies a shift of 2^k when shamt[k]=1, else passes data through unchanged.
//    LSL fills with 0. LSR fills with 0.
//    ASR fills with the original in_data[WIDTH-1]; this sign bit is carried down the pipe.
//    ROR wraps bits around.
//  - Latency: accepted in cycle N -> out_valid=1 in cycle N+SHW (3 with defaults).
//  - Advance: stage k loads when it is empty or stage k+1 loads this cycle.
//    The last stage loads when it is empty or out_ready=1.
//    in_ready = !v0 || stage1 loads (combinational; no bubbles required).
//  - Stall: while out_valid && !out_ready, out_data, out_carry and out_zero hold stable.
//    Upstream stages fill; in_ready=0 only when all SHW stages are valid and the last stage stalls.
//  - Simultaneous: accept on in_* and drain on out_* in the same cycle is legal.
//    Occupancy is unchanged in that case.
//  - shamt=0: out_data=in_data for all modes and out_carry=0.
//  - out_valid never drops without a transfer; out_data never changes while unaccepted.
//  - Reset asserted mid-operation discards all in-flight ops; no partial result is ever emitted.
// CONFIGURATION
//  SHIFT_STATUS_EN defined:
//    out_carry/out_zero ports exist and are pipelined alongside the data.
//    For shamt s>0: LSL carry=in_data[WIDTH-s]; LSR/ASR carry=in_data[s-1];
//    ROR carry=out_data[WIDTH-1].
//    out_zero=(out_data==0).
//  SHIFT_STATUS_EN undefined:
//    out_carry/out_zero ports and their flag registers are omitted.
//    Data path timing and behaviour are identical.
// TESTING
//  1 LSL: 0x96 sh3 -> 0xB0, carry 0, zero 0, out_valid exactly 3 cycles after accept.
//  2 ASR/LSR: 0x96 ASR sh2 -> 0xE5, carry 1; 0x80 LSR sh7 -> 0x01, carry 0.
//  3 ROR/zero: 0x81 ROR sh1 -> 0xC0, carry 1; 0x01 LSL sh1 -> 0x02;
//    0x01 LSR sh1 -> 0x00, zero 1, carry 1.
//  4 Throughput: 8 back-to-back ops with out_ready=1 -> in_ready stays 1;
//    8 results arrive on consecutive cycles, in issue order.
//  5 Backpressure: out_ready=0, issue 4 ops -> 3 accepted, then in_ready=0 and out_data stable.
//    Raise out_ready -> all 4 results emerge in order, unaltered.
//  6 Reset mid-op: rst_n=0 with 2 ops in flight -> out_valid=0 immediately;
//    after release, no stale result appears and in_ready=1.

Source files
------------

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: pipelined barrel shifter with WIDTH-bit data.
// Stage k conditionally shifts by 2^k, so a result takes SHW stages.
// Modes: 00 LSL, 01 LSR, 10 ASR (sign of the original operand), 11 ROR.
// Optional build macro SHIFT_STATUS_EN adds the out_carry/out_zero flags,
// which are carried down the pipe alongside the data.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is combinational (no bubble needed between ops).
// Once out_valid rises it stays high, and out_* stays unchanged, until the
// consumer takes the result with out_ready.

module barrel_shift_pipe #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef SHIFT_STATUS_EN
   ,
   output logic             out_carry,
   output logic             out_zero
`endif
);

   localparam logic [1:0] M_LSL = 2'b00;
   localparam logic [1:0] M_LSR = 2'b01;
   localparam logic [1:0] M_ASR = 2'b10;
   localparam logic [1:0] M_ROR = 2'b11;

   // One shift step of n positions (0 < n < WIDTH) in the given mode.
   function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                   input logic [1:0] m,
                                                   input logic sign,
                                                   input int n);
      logic [WIDTH-1:0] ones;
      logic [WIDTH-1:0] r;
      ones = '1;
      case (m)
         M_LSL:   r = d << n;
         M_LSR:   r = d >> n;
         M_ASR:   r = (d >> n) | (sign ? ~(ones >> n) : '0);
         default: r = (d >> n) | (d << (WIDTH - n));
      endcase
      return r;
   endfunction

`ifdef SHIFT_STATUS_EN
   // Last bit pushed out by one step. Chaining steps gives the bit pushed
   // out by the full shift, since the later step always reaches further.
   function automatic logic carry_step(input logic [WIDTH-1:0] d,
                                       input logic [1:0] m,
                                       input logic [WIDTH-1:0] shifted,
                                       input int n);
      logic [WIDTH-1:0] t;
      logic             c;
      t = '0;
      case (m)
         M_LSL: begin
            t = d >> (WIDTH - n);
            c = t[0];
         end
         M_LSR, M_ASR: begin
            t = d >> (n - 1);
            c = t[0];
         end
         default: c = shifted[WIDTH-1];
      endcase
      return c;
   endfunction
`endif

   // Stage registers, index k = stage k.
   logic [SHW-1:0]            valid_q;
   logic [SHW-1:0][WIDTH-1:0] data_q;
   logic [SHW-1:0][SHW-1:0]   shamt_q;
   logic [SHW-1:0][1:0]       mode_q;
   logic [SHW-1:0]            sign_q;

   // Stage inputs (from the port for stage 0, else from the previous stage).
   logic [SHW-1:0]            src_valid;
   logic [SHW-1:0][WIDTH-1:0] src_data;
   logic [SHW-1:0][SHW-1:0]   src_shamt;
   logic [SHW-1:0][1:0]       src_mode;
   logic [SHW-1:0]            src_sign;
   logic [SHW-1:0][WIDTH-1:0] nxt_data;
   logic [SHW-1:0]            load;

`ifdef SHIFT_STATUS_EN
   logic [SHW-1:0] carry_q;
   logic           zero_q;
   logic [SHW-1:0] src_carry;
   logic [SHW-1:0] nxt_carry;
`else
   // Flags are not built; the data path below is the same either way.
`endif

   // Route each stage's source and apply its conditional 2^k shift.
   always_comb begin
      src_valid[0] = in_valid;
      src_data[0]  = in_data;
      src_shamt[0] = in_shamt;
      src_mode[0]  = in_mode;
      src_sign[0]  = in_data[WIDTH-1];
`ifdef SHIFT_STATUS_EN
      src_carry[0] = 1'b0;
`endif
      for (int k = 1; k < SHW; k++) begin
         src_valid[k] = valid_q[k-1];
         src_data[k]  = data_q[k-1];
         src_shamt[k] = shamt_q[k-1];
         src_mode[k]  = mode_q[k-1];
         src_sign[k]  = sign_q[k-1];
`ifdef SHIFT_STATUS_EN
         src_carry[k] = carry_q[k-1];
`endif
      end
      for (int k = 0; k < SHW; k++) begin
         if (src_shamt[k][k]) begin
            nxt_data[k] = shift_step(src_data[k], src_mode[k], src_sign[k], 1 << k);
         end else begin
            nxt_data[k] = src_data[k];
         end
`ifdef SHIFT_STATUS_EN
         if (src_shamt[k][k]) begin
            nxt_carry[k] = carry_step(src_data[k], src_mode[k], nxt_data[k], 1 << k);
         end else begin
            nxt_carry[k] = src_carry[k];
         end
`endif
      end
   end

   // A stage loads when empty or when the stage after it loads; the last
   // stage loads when empty or the consumer accepts.
   always_comb begin
      logic acc;
      acc = out_ready;
      for (int k = SHW - 1; k >= 0; k--) begin
         acc     = acc || !valid_q[k];
         load[k] = acc;
      end
   end

   assign in_ready  = load[0];
   assign out_valid = valid_q[SHW-1];
   assign out_data  = data_q[SHW-1];

   // Pipeline registers; payload only updates when a valid op moves in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
         shamt_q <= '0;
         mode_q  <= '0;
         sign_q  <= '0;
`ifdef SHIFT_STATUS_EN
         carry_q <= '0;
         zero_q  <= 1'b0;
`endif
      end else begin
         for (int k = 0; k < SHW; k++) begin
            if (load[k]) begin
               valid_q[k] <= src_valid[k];
               if (src_valid[k]) begin
                  data_q[k]  <= nxt_data[k];
                  shamt_q[k] <= src_shamt[k];
                  mode_q[k]  <= src_mode[k];
                  sign_q[k]  <= src_sign[k];
`ifdef SHIFT_STATUS_EN
                  carry_q[k] <= nxt_carry[k];
`endif
               end
            end
         end
`ifdef SHIFT_STATUS_EN
         if (load[SHW-1] && src_valid[SHW-1]) begin
            zero_q <= (nxt_data[SHW-1] == '0);
         end
`endif
      end
   end

`ifdef SHIFT_STATUS_EN
   assign out_carry = carry_q[SHW-1];
   assign out_zero  = zero_q;
`endif

   // The last stage's control fields and already-consumed shamt bits have
   // no reader; fold them into one sink so the intent is explicit.
   logic unused_bits;
   assign unused_bits = ^{shamt_q, mode_q[SHW-1], sign_q[SHW-1]};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: directed table, multi-cycle corner sequences and
// randomized traffic checked by an arithmetic reference model.
// Flags are compared only when SHIFT_STATUS_EN is defined.

module tb_barrel_shift_pipe;
  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef SHIFT_STATUS_EN
  logic             out_carry;
  logic             out_zero;
`endif

  barrel_shift_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SHIFT_STATUS_EN
    ,
    .out_carry (out_carry),
    .out_zero  (out_zero)
`endif
  );

  // result word: {carry, zero, data}
  typedef logic [WIDTH+1:0] res_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic res_t mask_res(input res_t r);
    res_t m;
    m = r;
`ifndef SHIFT_STATUS_EN
    m[WIDTH+1:WIDTH] = 2'b00;
`endif
    return m;
  endfunction

  function automatic res_t dut_res();
`ifdef SHIFT_STATUS_EN
    return {out_carry, out_zero, out_data};
`else
    return {2'b00, out_data};
`endif
  endfunction

  // Reference model: plain integer arithmetic on the whole operand.
  function automatic res_t model(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
    int x, sh, r, c, sx;
    x  = int'(d);
    sh = int'(s);
    r  = 0;
    c  = 0;
    case (m)
      2'd0: begin
        r = (x << sh) & 255;
        c = ((x << sh) >> 8) & 1;          // bit that crossed the top edge
      end
      2'd1: begin
        r = x >> sh;
        c = (sh != 0) ? ((x >> (sh - 1)) & 1) : 0;
      end
      2'd2: begin
        sx = (x >= 128) ? x - 256 : x;
        r  = (sx >>> sh) & 255;
        c  = (sh != 0) ? ((x >> (sh - 1)) & 1) : 0;
      end
      default: begin
        r = ((x | (x << 8)) >> sh) & 255;
        c = (sh != 0) ? ((r >> 7) & 1) : 0;
      end
    endcase
    return mask_res({c[0], (r == 0), r[7:0]});
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [WIDTH+1:0] exp_q[$];
  int               xfer_q[$];
  logic             prev_stall = 1'b0;
  res_t             held;

  always @(negedge clk) begin
    res_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", int'(out_valid), 1);
        chk("stall_data_hold", int'(dut_res()), int'(held));
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_data, in_shamt, in_mode));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("scoreboard", int'(dut_res()), int'(e));
        end
        xfer_q.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      held       = dut_res();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
    in_valid = v;
    in_data  = d;
    in_shamt = s;
    in_mode  = m;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk({name, "_drain_timeout"}, 1, 0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic [1:0] m;
    logic [7:0] ed;
    logic       ec;
    logic       ez;
  } vec_t;

  vec_t vecs[9];

  // One op into an idle pipe: measure latency and compare against the table.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    @(posedge clk); #1;
    drive(1'b1, v.d, v.s, v.m);
    @(negedge clk);
    chk($sformatf("vec%0d_in_ready", idx), int'(in_ready), 1);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 3'd0, 2'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk($sformatf("vec%0d_latency", idx), n, 3);
    chk($sformatf("vec%0d_data", idx), int'(out_data), int'(v.ed));
`ifdef SHIFT_STATUS_EN
    chk($sformatf("vec%0d_carry", idx), int'(out_carry), int'(v.ec));
    chk($sformatf("vec%0d_zero", idx), int'(out_zero), int'(v.ez));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic       acc;
    res_t       first_exp;
    int         seen;
    logic [7:0] bp_d[4];

    vecs[0] = '{8'h96, 3'd3, 2'd0, 8'hB0, 1'b0, 1'b0};
    vecs[1] = '{8'h96, 3'd2, 2'd2, 8'hE5, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 3'd7, 2'd1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'h81, 3'd1, 2'd3, 8'hC0, 1'b1, 1'b0};
    vecs[4] = '{8'h01, 3'd1, 2'd0, 8'h02, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 3'd1, 2'd1, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'hA5, 3'd0, 2'd3, 8'hA5, 1'b0, 1'b0};
    vecs[7] = '{8'h80, 3'd7, 2'd2, 8'hFF, 1'b0, 1'b0};
    vecs[8] = '{8'h96, 3'd4, 2'd3, 8'h69, 1'b0, 1'b0};

    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 3'd0, 2'd0);
    #12;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
`ifdef SHIFT_STATUS_EN
    chk("reset_out_carry", int'(out_carry), 0);
    chk("reset_out_zero", int'(out_zero), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);

    // directed table
    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);
    wait_drain("table");

    // throughput: 8 back-to-back ops
    xfer_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      @(negedge clk);
      chk("thru_in_ready", int'(in_ready), 1);
    end
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 3'd0, 2'd0);
    wait_drain("thru");
    chk("thru_count", xfer_q.size(), 8);
    if (xfer_q.size() == 8) chk("thru_consecutive", xfer_q[7] - xfer_q[0], 7);

    // backpressure: 4 ops with consumer stalled
    xfer_q.delete();
    bp_d = '{8'h3C, 8'hC3, 8'h5A, 8'hF0};
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      drive(1'b1, bp_d[i], 3'(i + 1), 2'(i));
      @(negedge clk);
      chk($sformatf("bp_in_ready%0d", i), int'(in_ready), (i < 3) ? 1 : 0);
    end
    first_exp = model(bp_d[0], 3'd1, 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_stalled", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_data", int'(out_data), int'(first_exp[WIDTH-1:0]));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 3'd0, 2'd0);
    wait_drain("bp");
    chk("bp_count", xfer_q.size(), 4);

    // reset with ops in flight
    @(posedge clk); #1;
    drive(1'b1, 8'h12, 3'd1, 2'd0);
    @(posedge clk); #1;
    drive(1'b1, 8'h34, 3'd2, 2'd1);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 3'd0, 2'd0);
    @(posedge clk); #1;
    chk("pre_reset_out_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_reset_out_valid", int'(out_valid), 0);
    chk("mid_reset_out_data", int'(out_data), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", int'(in_ready), 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("post_reset_no_stale", seen, 0);

    // randomized traffic with random backpressure
    acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        drive(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
              3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
    end
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 3'd0, 2'd0);
    out_ready = 1'b1;
    wait_drain("random");
    chk("random_scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
